// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 immediate stage: field formats, opcodes and the
// buffer entry record.
package lc3_pkg;

  // Widest datapath a buffer entry can carry; the stage uses the low W bits.
  localparam int unsigned WMAX = 64;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_IMM5  = 3'd1,
    FMT_OFF6  = 3'd2,
    FMT_OFF9  = 3'd3,
    FMT_OFF11 = 3'd4,
    FMT_TRAP8 = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  typedef struct packed {
    logic [15:0]     ir;
    logic [WMAX-1:0] imm;
    fmt_e            fmt;
    logic [WMAX-1:0] ea;
    logic            ea_valid;
  } entry_t;

endpackage

// File: rtl/lc3_imm_decode.sv
// Combinational LC-3 field extender: picks the immediate/offset field for the
// opcode, extends it to W bits and forms the PC-relative or trap address.
module lc3_imm_decode
  import lc3_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter bit          EA_EN = 1'b1
) (
  input  logic [15:0]  ir_i,
  input  logic [W-1:0] pc_i,
  output logic [W-1:0] imm_o,
  output logic [2:0]   fmt_o,
  output logic [W-1:0] ea_o,
  output logic         ea_valid_o
);

  fmt_e fmt;
  logic pc_rel;
  logic is_trap;

  always_comb begin
    fmt = FMT_NONE;
    case (ir_i[15:12])
      OP_ADD, OP_AND:                              fmt = ir_i[5] ? FMT_IMM5 : FMT_NONE;
      OP_LDR, OP_STR:                              fmt = FMT_OFF6;
      OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: fmt = FMT_OFF9;
      OP_JSR:                                      fmt = ir_i[11] ? FMT_OFF11 : FMT_NONE;
      OP_TRAP:                                     fmt = FMT_TRAP8;
      OP_RTI, OP_NOT, OP_JMP, OP_RES:              fmt = FMT_NONE;
      default:                                     fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (fmt)
      FMT_IMM5:  imm_o = {{(W-5){ir_i[4]}},   ir_i[4:0]};
      FMT_OFF6:  imm_o = {{(W-6){ir_i[5]}},   ir_i[5:0]};
      FMT_OFF9:  imm_o = {{(W-9){ir_i[8]}},   ir_i[8:0]};
      FMT_OFF11: imm_o = {{(W-11){ir_i[10]}}, ir_i[10:0]};
      FMT_TRAP8: imm_o = {{(W-8){1'b0}},      ir_i[7:0]};
      default:   imm_o = '0;
    endcase
  end

  always_comb begin
    pc_rel     = (fmt == FMT_OFF9) || (fmt == FMT_OFF11);
    is_trap    = (fmt == FMT_TRAP8);
    fmt_o      = fmt;
    ea_o       = '0;
    ea_valid_o = 1'b0;
    if (EA_EN) begin
      ea_valid_o = pc_rel || is_trap;
      if (pc_rel) begin
        ea_o = pc_i + imm_o;
      end else if (is_trap) begin
        ea_o = imm_o;
      end
    end
  end

endmodule

// File: rtl/lc3_imm_stage.sv
// Registered LC-3 immediate stage: decode ahead of a two-entry skid buffer with
// valid/ready handshake, flush, and fully registered outputs.
module lc3_imm_stage
  import lc3_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter bit          EA_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  ir,
  input  logic [W-1:0] pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_ir,
  output logic [W-1:0] imm,
  output logic [2:0]   fmt,
  output logic [W-1:0] ea,
  output logic         ea_valid
);

  occ_e   occ_q, occ_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t dec;

  logic [W-1:0] dec_imm;
  logic [W-1:0] dec_ea;
  logic [2:0]   dec_fmt;
  logic         dec_ea_valid;
  logic         accept;
  logic         drain;

  lc3_imm_decode #(
    .W     (W),
    .EA_EN (EA_EN)
  ) u_decode (
    .ir_i       (ir),
    .pc_i       (pc),
    .imm_o      (dec_imm),
    .fmt_o      (dec_fmt),
    .ea_o       (dec_ea),
    .ea_valid_o (dec_ea_valid)
  );

  always_comb begin
    dec          = '0;
    dec.ir       = ir;
    dec.imm      = WMAX'(dec_imm);
    dec.fmt      = fmt_e'(dec_fmt);
    dec.ea       = WMAX'(dec_ea);
    dec.ea_valid = dec_ea_valid;
  end

  // in_ready is a flop, so accept never depends combinationally on out_ready.
  assign accept = in_valid & in_ready_q & ~flush;
  assign drain  = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (accept) occ_d = OCC_ONE;
        OCC_ONE: begin
          if (accept && !drain)      occ_d = OCC_TWO;
          else if (!accept && drain) occ_d = OCC_EMPTY;
        end
        OCC_TWO:   if (drain) occ_d = OCC_ONE;
        default:   occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready_d  = (occ_d != OCC_TWO);
    out_valid_d = (occ_d != OCC_EMPTY);
  end

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    case (occ_q)
      OCC_EMPTY: if (accept) head_d = dec;
      OCC_ONE: begin
        if (accept && drain) head_d = dec;
        else if (accept)     skid_d = dec;
      end
      OCC_TWO:   if (drain) head_d = skid_q;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ir    = head_q.ir;
  assign imm       = W'(head_q.imm);
  assign fmt       = head_q.fmt;
  assign ea        = W'(head_q.ea);
  assign ea_valid  = head_q.ea_valid;

  if (W < WMAX) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{head_q.imm[WMAX-1:W], head_q.ea[WMAX-1:W]};
  end

endmodule

// File: tb/tb_lc3_imm_stage.sv
// Bench for lc3_imm_stage: W=16 and W=32 instances share stimulus; a FIFO
// scoreboard with an arithmetic field model checks every cycle.
module tb_lc3_imm_stage;
  import lc3_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] ir;
  logic [15:0] pc16;
  logic [31:0] pc32;

  logic        in_ready16, out_valid16, eav16;
  logic [15:0] out_ir16, imm16, ea16;
  logic [2:0]  fmt16;
  logic        in_ready32, out_valid32, eav32;
  logic [15:0] out_ir32;
  logic [31:0] imm32, ea32;
  logic [2:0]  fmt32;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  lc3_imm_stage #(.W(16), .EA_EN(1'b1)) dut16 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
    .ir(ir), .pc(pc16), .out_valid(out_valid16), .out_ready(out_ready), .out_ir(out_ir16),
    .imm(imm16), .fmt(fmt16), .ea(ea16), .ea_valid(eav16)
  );

  lc3_imm_stage #(.W(32), .EA_EN(1'b1)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .ir(ir), .pc(pc32), .out_valid(out_valid32), .out_ready(out_ready), .out_ir(out_ir32),
    .imm(imm32), .fmt(fmt32), .ea(ea32), .ea_valid(eav32)
  );

  typedef struct {
    logic [2:0]      fmt;
    longint unsigned imm;
    longint unsigned ea;
    bit              eav;
  } exp_t;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc16;
    logic [31:0] pc32;
  } txn_t;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] imm;
    logic [2:0]  fmt;
    logic [15:0] ea;
    logic        eav;
    logic [31:0] imm32;
    logic [31:0] ea32;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Field value as a signed integer taken straight from the opcode table.
  function automatic exp_t ref_model(input logic [15:0] i, input longint unsigned p,
                                     input int unsigned w);
    exp_t            e;
    longint unsigned mask = (64'd1 << w) - 64'd1;
    int              nb   = 0;
    bit              sgn  = 1'b1;
    longint unsigned fld;
    longint          sv;
    e.fmt = FMT_NONE;
    case (i[15:12])
      4'h1, 4'h5: if (i[5]) begin e.fmt = FMT_IMM5; nb = 5; end
      4'h6, 4'h7: begin e.fmt = FMT_OFF6; nb = 6; end
      4'h0, 4'h2, 4'h3, 4'hA, 4'hB, 4'hE: begin e.fmt = FMT_OFF9; nb = 9; end
      4'h4: if (i[11]) begin e.fmt = FMT_OFF11; nb = 11; end
      4'hF: begin e.fmt = FMT_TRAP8; nb = 8; sgn = 1'b0; end
      default: ;
    endcase
    fld = longint'(i) & ((64'd1 << nb) - 64'd1);
    sv  = longint'(fld);
    if (sgn && nb > 0 && fld >= (64'd1 << (nb - 1))) sv = sv - longint'(64'd1 << nb);
    e.imm = longint'(sv) & mask;
    e.eav = (e.fmt == FMT_OFF9) || (e.fmt == FMT_OFF11) || (e.fmt == FMT_TRAP8);
    if ((e.fmt == FMT_OFF9) || (e.fmt == FMT_OFF11)) e.ea = (p + longint'(sv)) & mask;
    else if (e.fmt == FMT_TRAP8)                     e.ea = e.imm;
    else                                             e.ea = 64'd0;
    return e;
  endfunction

  txn_t q[$];
  exp_t e16, e32;
  bit   do_pop, do_push;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready16", in_ready16, q.size() < 2);
      chk("in_ready32", in_ready32, q.size() < 2);
      chk("out_valid16", out_valid16, q.size() > 0);
      chk("out_valid32", out_valid32, q.size() > 0);
      if (q.size() > 0) begin
        e16 = ref_model(q[0].ir, longint'(q[0].pc16), 16);
        e32 = ref_model(q[0].ir, longint'(q[0].pc32), 32);
        chk("out_ir16", out_ir16, q[0].ir);
        chk("imm16", imm16, e16.imm);
        chk("fmt16", fmt16, e16.fmt);
        chk("ea16", ea16, e16.ea);
        chk("eav16", eav16, e16.eav);
        chk("out_ir32", out_ir32, q[0].ir);
        chk("imm32", imm32, e32.imm);
        chk("fmt32", fmt32, e32.fmt);
        chk("ea32", ea32, e32.ea);
        chk("eav32", eav32, e32.eav);
      end
    end
    if (reset || flush) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{ir, pc16, pc32});
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {out_valid16, out_valid32}, 2'b00);
    chk({tag, "_in_ready"}, {in_ready16, in_ready32}, 2'b11);
    chk({tag, "_out_ir"}, {out_ir16, out_ir32}, 32'h0);
    chk({tag, "_imm"}, {imm16, imm32}, 48'h0);
    chk({tag, "_fmt"}, {fmt16, fmt32}, {FMT_NONE, FMT_NONE});
    chk({tag, "_ea"}, {ea16, ea32}, 48'h0);
    chk({tag, "_eav"}, {eav16, eav32}, 2'b00);
  endtask

  vec_t        tab[13];
  logic [15:0] got[$];
  bit          c_taken;
  int          cyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = '{16'h12BD, 16'h3000, 16'hFFFD, FMT_IMM5,  16'h0000, 1'b0, 32'hFFFFFFFD, 32'h00000000};
    tab[1]  = '{16'h1283, 16'h3000, 16'h0000, FMT_NONE,  16'h0000, 1'b0, 32'h00000000, 32'h00000000};
    tab[2]  = '{16'h0FFE, 16'h3001, 16'hFFFE, FMT_OFF9,  16'h2FFF, 1'b1, 32'hFFFFFFFE, 32'h00002FFF};
    tab[3]  = '{16'h4C00, 16'h3000, 16'hFC00, FMT_OFF11, 16'h2C00, 1'b1, 32'hFFFFFC00, 32'h00002C00};
    tab[4]  = '{16'hF0A5, 16'h3000, 16'h00A5, FMT_TRAP8, 16'h00A5, 1'b1, 32'h000000A5, 32'h000000A5};
    tab[5]  = '{16'h6A3F, 16'h1234, 16'hFFFF, FMT_OFF6,  16'h0000, 1'b0, 32'hFFFFFFFF, 32'h00000000};
    tab[6]  = '{16'h4080, 16'h3000, 16'h0000, FMT_NONE,  16'h0000, 1'b0, 32'h00000000, 32'h00000000};
    tab[7]  = '{16'h8000, 16'h3000, 16'h0000, FMT_NONE,  16'h0000, 1'b0, 32'h00000000, 32'h00000000};
    tab[8]  = '{16'hE0FF, 16'h3000, 16'h00FF, FMT_OFF9,  16'h30FF, 1'b1, 32'h000000FF, 32'h000030FF};
    tab[9]  = '{16'hB100, 16'h0050, 16'hFF00, FMT_OFF9,  16'hFF50, 1'b1, 32'hFFFFFF00, 32'hFFFFFF50};
    tab[10] = '{16'h5030, 16'h3000, 16'hFFF0, FMT_IMM5,  16'h0000, 1'b0, 32'hFFFFFFF0, 32'h00000000};
    tab[11] = '{16'hF0FF, 16'h3000, 16'h00FF, FMT_TRAP8, 16'h00FF, 1'b1, 32'h000000FF, 32'h000000FF};
    tab[12] = '{16'hEFFF, 16'hFFFF, 16'hFFFF, FMT_OFF9,  16'hFFFE, 1'b1, 32'hFFFFFFFF, 32'h0000FFFE};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ir = '0; pc16 = '0; pc32 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");

    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1 in_valid = 1'b1; ir = tab[i].ir; pc16 = tab[i].pc; pc32 = {16'h0000, tab[i].pc};
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid16, 1'b1);
      chk($sformatf("vec%0d_imm16", i), imm16, tab[i].imm);
      chk($sformatf("vec%0d_fmt", i), fmt16, tab[i].fmt);
      chk($sformatf("vec%0d_ea16", i), ea16, tab[i].ea);
      chk($sformatf("vec%0d_eav", i), eav16, tab[i].eav);
      chk($sformatf("vec%0d_imm32", i), imm32, tab[i].imm32);
      chk($sformatf("vec%0d_ea32", i), ea32, tab[i].ea32);
    end

    // Backpressure: A, B fill the buffer, C waits, then all drain in order.
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b1; ir = 16'h12BD; pc16 = 16'h3000; pc32 = 32'h3000;
    @(posedge clk);
    #1 ir = 16'h0FFE; pc16 = 16'h3001; pc32 = 32'h3001;
    @(posedge clk);
    #1 ir = 16'hF0A5;
    @(negedge clk);
    chk("bp_full_in_ready", in_ready16, 1'b0);
    chk("bp_head_ir", out_ir16, 16'h12BD);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_stall_in_ready", in_ready16, 1'b0);
    chk("bp_stall_ir", out_ir16, 16'h12BD);
    chk("bp_stall_imm", imm16, 16'hFFFD);
    @(posedge clk);
    #1 out_ready = 1'b1;
    c_taken = 1'b0;
    got.delete();
    cyc = 0;
    while (got.size() < 3 && cyc < 20) begin
      @(negedge clk);
      if (out_valid16 && out_ready) got.push_back(out_ir16);
      if (in_valid && in_ready16) c_taken = 1'b1;
      @(posedge clk);
      #1 if (c_taken) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_order0", got[0], 16'h12BD);
      chk("bp_order1", got[1], 16'h0FFE);
      chk("bp_order2", got[2], 16'hF0A5);
    end

    // Flush at occupancy TWO with a new input presented.
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b1; ir = 16'h6A3F;
    @(posedge clk);
    #1 ir = 16'hE0FF;
    @(posedge clk);
    #1 ir = 16'hB100; flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {out_valid16, out_valid32}, 2'b00);
    chk("flush_in_ready", {in_ready16, in_ready32}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_no_emit", out_valid16, 1'b0);
    end

    // Reset together with flush at occupancy TWO, then single-cycle latency.
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b1; ir = 16'h4C00; pc16 = 16'h3000; pc32 = 32'h3000;
    @(posedge clk);
    #1 ir = 16'h5030;
    @(posedge clk);
    #1 reset = 1'b1; flush = 1'b1; ir = 16'h1283;
    @(posedge clk);
    #1 reset = 1'b0; flush = 1'b0; ir = 16'hF0A5; out_ready = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst2");
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_lat_valid", out_valid16, 1'b1);
    chk("rst2_lat_ir", out_ir16, 16'hF0A5);
    chk("rst2_lat_imm", imm16, 16'h00A5);

    // Random traffic against the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      ir        = 16'($urandom);
      pc16      = 16'($urandom);
      pc32      = $urandom;
    end
    @(posedge clk);
    #1 reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
